// File: rtl/deser_pkg.sv
// Shared types and helpers for the deserializador receive stage.
// Contents: state enum, byte width, default comma character, bad-byte test.
package deser_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COMMA_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} deser_state_e;

  // A control character other than the comma is a framing error; data bytes are always good.
  function automatic logic is_bad(input logic [BYTE_W-1:0] data, input logic dk,
                                  input logic [BYTE_W-1:0] comma);
    return dk && (data != comma);
  endfunction

endpackage

// File: rtl/deser_align.sv
// Bit alignment front end: serial shift register, bit counter and boundary detect.
// Ports:
//   clk, reset  - bit clock, asynchronous active-high reset
//   in          - serial data, MSB first
//   count_en    - high while aligned (CHECK/LOCKED); low holds the bit counter at 0
//   cand        - candidate byte: the last 7 shifted bits plus the bit on in
//   boundary    - cand is a complete aligned byte this cycle
module deser_align
  import deser_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  input  logic              count_en,
  output logic [BYTE_W-1:0] cand,
  output logic              boundary
);

  localparam int unsigned CntW = $clog2(BYTE_W);

  // Only the low 7 bits of the shift history ever reach cand, so the 8th is not stored.
  logic [BYTE_W-2:0] shreg_q;
  logic [CntW-1:0]   bit_cnt_q;

  assign cand     = {shreg_q, in};
  assign boundary = count_en && (bit_cnt_q == CntW'(BYTE_W - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= cand[BYTE_W-2:0];
      // Held at 0 while searching so the cycle after a comma hit is bit 0 of the next byte.
      bit_cnt_q <= count_en ? bit_cnt_q + CntW'(1) : '0;
    end
  end

endmodule

// File: rtl/deserializador.sv
// Serial-to-parallel receive stage with comma-based byte alignment and lock tracking.
// Ports:
//   clk, reset  - bit clock, asynchronous active-high reset
//   in, dk_in   - serial data (MSB first) and DK flag of the byte in flight
//   data_out    - last aligned byte, dk_out its DK flag
//   valid       - one-cycle strobe when data_out/dk_out update (LOCKED only)
//   sync        - high while LOCKED
//   err         - one-cycle strobe per bad byte while LOCKED
//   err_total   - saturating error count, present only with DESER_ERR_CNT_EN defined
module deserializador
  import deser_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA      = COMMA_DEFAULT,
  parameter int unsigned       SYNC_COUNT = 4,
  parameter int unsigned       LOSS_COUNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  input  logic              dk_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              dk_out,
  output logic              valid,
  output logic              sync,
  output logic              err
`ifdef DESER_ERR_CNT_EN
  ,
  output logic [15:0]       err_total
`endif
);

  localparam logic [3:0] SyncCnt = 4'(SYNC_COUNT);
  localparam logic [3:0] LossCnt = 4'(LOSS_COUNT);

  deser_state_e      state_q;
  logic [3:0]        sync_cnt_q;
  logic [3:0]        err_cnt_q;
  logic [BYTE_W-1:0] data_q;
  logic              dk_q;
  logic              valid_q;
  logic              sync_q;
  logic              err_q;

  logic [BYTE_W-1:0] cand;
  logic              boundary;
  logic              comma_hit;
  logic              err_fire;
  logic              loss;

  deser_align u_align (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .count_en (state_q != SEARCH),
    .cand     (cand),
    .boundary (boundary)
  );

  assign comma_hit = (cand == COMMA) && dk_in;
  assign err_fire  = (state_q == LOCKED) && boundary && is_bad(cand, dk_in, COMMA);
  assign loss      = err_fire && ((err_cnt_q + 4'd1) == LossCnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SEARCH;
      sync_cnt_q <= '0;
      err_cnt_q  <= '0;
      data_q     <= '0;
      dk_q       <= 1'b0;
      valid_q    <= 1'b0;
      sync_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        SEARCH: begin
          if (comma_hit) begin
            sync_cnt_q <= 4'd1;
            if (SyncCnt == 4'd1) begin
              state_q   <= LOCKED;
              sync_q    <= 1'b1;
              err_cnt_q <= '0;
            end else begin
              state_q <= CHECK;
            end
          end
        end
        CHECK: begin
          if (boundary) begin
            if (comma_hit) begin
              sync_cnt_q <= sync_cnt_q + 4'd1;
              if ((sync_cnt_q + 4'd1) == SyncCnt) begin
                state_q   <= LOCKED;
                sync_q    <= 1'b1;
                err_cnt_q <= '0;
              end
            end else begin
              state_q    <= SEARCH;
              sync_cnt_q <= '0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            data_q  <= cand;
            dk_q    <= dk_in;
            valid_q <= 1'b1;
            if (err_fire) begin
              err_q     <= 1'b1;
              err_cnt_q <= err_cnt_q + 4'd1;
              // The failing byte is still delivered; only the lock is dropped.
              if (loss) begin
                state_q    <= SEARCH;
                sync_q     <= 1'b0;
                sync_cnt_q <= '0;
              end
            end else begin
              err_cnt_q <= '0;
            end
          end
        end
        default: begin
          state_q <= SEARCH;
          sync_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = data_q;
  assign dk_out   = dk_q;
  assign valid    = valid_q;
  assign sync     = sync_q;
  assign err      = err_q;

`ifdef DESER_ERR_CNT_EN
  logic [15:0] err_total_q;
  logic [16:0] err_sum;

  // A loss cycle counts twice: once for the err pulse, once for the lock drop.
  assign err_sum = {1'b0, err_total_q} + {15'd0, err_fire} + {15'd0, loss};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_total_q <= '0;
    end else begin
      err_total_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign err_total = err_total_q;
`endif

endmodule

// File: tb/tb_deserializador.sv
// Self-checking bench for deserializador: directed scenarios followed by random byte/bit
// streams, compared every cycle against a bit-history reference model.
module tb_deserializador;

  localparam logic [7:0] Comma = 8'hBC;
  localparam int         SyncN = 4;
  localparam int         LossN = 4;

  logic       clk;
  logic       reset;
  logic       ser_in;
  logic       dk_in;
  logic [7:0] data_out;
  logic       dk_out;
  logic       valid;
  logic       sync;
  logic       err;
`ifdef DESER_ERR_CNT_EN
  logic [15:0] err_total;
`endif

  int n_checks = 0;
  int n_errors = 0;

  deserializador dut (
    .clk      (clk),
    .reset    (reset),
    .in       (ser_in),
    .dk_in    (dk_in),
    .data_out (data_out),
    .dk_out   (dk_out),
    .valid    (valid),
    .sync     (sync),
    .err      (err)
`ifdef DESER_ERR_CNT_EN
    ,
    .err_total (err_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: alignment is tracked as the absolute cycle of the first comma hit,
  // byte ends fall every 8 cycles after it.
  int         m_cyc;
  int         m_mode;     // 0 searching, 1 counting commas, 2 locked
  int         m_anchor;
  int         m_commas;
  int         m_bad_run;
  logic [7:0] m_hist;
  logic [7:0] e_data;
  logic       e_dk;
  logic       e_valid;
  logic       e_err;
  logic       e_sync;
  int         e_total;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_mode = 0; m_anchor = 0; m_commas = 0; m_bad_run = 0; m_hist = 8'h00;
    e_data = 8'h00; e_dk = 1'b0; e_valid = 1'b0; e_err = 1'b0; e_sync = 1'b0; e_total = 0;
  endtask

  task automatic model_step(input logic b, input logic dk);
    logic [7:0] byte_v;
    logic       hit;
    logic       at_end;
    byte_v  = {m_hist[6:0], b};
    hit     = (byte_v == Comma) && dk;
    at_end  = (m_mode != 0) && (((m_cyc - m_anchor) % 8) == 0);
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (m_mode == 0) begin
      if (hit) begin
        m_anchor = m_cyc;
        m_commas = 1;
        if (m_commas == SyncN) begin m_mode = 2; m_bad_run = 0; end
        else m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (at_end) begin
        if (hit) begin
          m_commas++;
          if (m_commas == SyncN) begin m_mode = 2; m_bad_run = 0; end
        end else begin
          m_mode = 0;
          m_commas = 0;
        end
      end
    end else if (at_end) begin
      e_data  = byte_v;
      e_dk    = dk;
      e_valid = 1'b1;
      if (dk && byte_v != Comma) begin
        e_err = 1'b1;
        m_bad_run++;
        e_total = e_total + 1;
        if (m_bad_run == LossN) begin
          m_mode = 0;
          m_commas = 0;
          e_total = e_total + 1;
        end
      end else begin
        m_bad_run = 0;
      end
    end
    if (e_total > 65535) e_total = 65535;
    e_sync = (m_mode == 2);
    m_hist = byte_v;
    m_cyc++;
  endtask

  task automatic compare_all();
    check("valid", {15'd0, valid}, {15'd0, e_valid});
    check("err", {15'd0, err}, {15'd0, e_err});
    check("sync", {15'd0, sync}, {15'd0, e_sync});
    check("data_out", {8'd0, data_out}, {8'd0, e_data});
    check("dk_out", {15'd0, dk_out}, {15'd0, e_dk});
`ifdef DESER_ERR_CNT_EN
    check("err_total", err_total, 16'(e_total));
`endif
  endtask

  // One bit per cycle: drive, let the DUT and model take the edge, compare on the far edge.
  task automatic send_bit(input logic b, input logic dk);
    ser_in = b;
    dk_in  = dk;
    @(posedge clk);
    model_step(b, dk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dk);
    for (int i = 7; i >= 0; i--) send_bit(b[i], dk);
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) send_byte(Comma, 1'b1);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge.
  task automatic apply_reset();
    #2 reset = 1'b1;
    model_reset();
    #1 compare_all();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    compare_all();
  endtask

  initial begin
    logic [7:0] rb;
    int         sel;
    reset  = 1'b1;
    ser_in = 1'b0;
    dk_in  = 1'b0;
    model_reset();
    #1 compare_all();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Lock, then two data bytes.
    send_commas(4);
    check("locked_after_commas", {15'd0, sync}, 16'd1);
    send_byte(8'h55, 1'b0);
    send_byte(8'hA3, 1'b0);

    // Four bad control bytes drop lock.
    for (int i = 0; i < 4; i++) send_byte(8'h7C, 1'b1);
    check("unlocked_after_loss", {15'd0, sync}, 16'd0);

    // Relock; a good byte between bad runs keeps lock.
    send_commas(4);
    for (int i = 0; i < 3; i++) send_byte(8'h7C, 1'b1);
    send_byte(8'h12, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h7C, 1'b1);
    check("lock_held", {15'd0, sync}, 16'd1);
    send_byte(8'h7C, 1'b1);

    // Misaligned start, then realign on commas.
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_commas(4);
    send_byte(8'hF0, 1'b0);
    check("offset_data", {8'd0, data_out}, 16'h00F0);

    // Reset partway through a byte while locked.
    send_commas(4);
    for (int i = 7; i >= 3; i--) send_bit(rb[0] ^ 1'b1, 1'b0);
    apply_reset();
    send_commas(4);
    send_byte(8'h3C, 1'b0);

    // Random mix of commas, data, bad bytes, stray bits and occasional resets.
    for (int it = 0; it < 400; it++) begin
      sel = $urandom_range(0, 19);
      rb  = 8'($urandom_range(0, 255));
      if (sel < 6) send_byte(Comma, 1'b1);
      else if (sel < 8) begin
        for (int k = 0; k < int'($urandom_range(1, 7)); k++) send_bit(rb[k], 1'b0);
      end else if (sel < 10) send_byte((rb == Comma) ? 8'h1C : rb, 1'b1);
      else if (sel == 10) begin
        send_bit(rb[7], 1'b0);
        apply_reset();
      end else send_byte(rb, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
